// File: rtl/liteic_slave_rd_arbiter.sv
// Round-robin arbiter and sequencer for one slave node's shared AXI-Lite read port.
// A grant is held from selection through the AR handshake and the R handshake,
// then priority rotates to the slot after the one just served.
module liteic_slave_rd_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = (NUM_REQ == 1) ? 1 : $clog2(NUM_REQ)
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic                ar_hs_i,
  input  logic                r_hs_i,
  output logic                gnt_valid_o,
  output logic [NUM_REQ-1:0]  gnt_onehot_o,
  output logic [ID_WIDTH-1:0] gnt_id_o,
  output logic                busy_o,
  output logic                ar_done_o,
  output logic                proto_err_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAddr = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]          r_state;
  logic [ID_WIDTH-1:0] r_rr_ptr;
  logic [ID_WIDTH-1:0] r_gnt_id;
  logic [NUM_REQ-1:0]  r_gnt_onehot;
  logic                r_proto_err;

  logic [2*NUM_REQ-1:0] w_req_dbl;
  logic [2*NUM_REQ-1:0] w_req_rot;
  logic                 w_found;
  logic [ID_WIDTH:0]    w_idx;
  logic [ID_WIDTH-1:0]  w_sel_id;
  logic [NUM_REQ-1:0]   w_sel_onehot;
  logic [ID_WIDTH-1:0]  w_ptr_nxt;

  // Doubling the request vector and shifting by the pointer turns the wrap-around
  // search into a plain lowest-set-bit search over the bottom NUM_REQ bits.
  assign w_req_dbl = {req_i, req_i};
  assign w_req_rot = w_req_dbl >> r_rr_ptr;

  // Round-robin selection: first requesting slot at or after r_rr_ptr.
  always_comb begin
    w_found  = 1'b0;
    w_idx    = '0;
    w_sel_id = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_found && w_req_rot[k]) begin
        w_found = 1'b1;
        w_idx   = {1'b0, r_rr_ptr} + (ID_WIDTH+1)'(k);
        if (w_idx >= (ID_WIDTH+1)'(NUM_REQ)) begin
          w_idx = w_idx - (ID_WIDTH+1)'(NUM_REQ);
        end
        w_sel_id = ID_WIDTH'(w_idx);
      end
    end
  end

  // Binary-to-one-hot of the selected slot.
  always_comb begin
    w_sel_onehot = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_sel_onehot[i] = (w_sel_id == ID_WIDTH'(i));
    end
  end

  assign w_ptr_nxt = (r_gnt_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : r_gnt_id + 1'b1;

  // State machine, grant registers, priority pointer and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state      <= StIdle;
      r_rr_ptr     <= '0;
      r_gnt_id     <= '0;
      r_gnt_onehot <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (|req_i) begin
            r_state      <= StAddr;
            r_gnt_id     <= w_sel_id;
            r_gnt_onehot <= w_sel_onehot;
          end
          if (ar_hs_i || r_hs_i) r_proto_err <= 1'b1;
        end
        StAddr: begin
          // Grant is frozen here; only the AR handshake moves us on.
          if (ar_hs_i) begin
            r_state  <= StResp;
            r_rr_ptr <= w_ptr_nxt;
          end
          if (r_hs_i) r_proto_err <= 1'b1;
        end
        StResp: begin
          if (r_hs_i) begin
            if (|req_i) begin
              // Back-to-back grant using the already-rotated pointer.
              r_state      <= StAddr;
              r_gnt_id     <= w_sel_id;
              r_gnt_onehot <= w_sel_onehot;
            end else begin
              r_state      <= StIdle;
              r_gnt_onehot <= '0;
            end
          end
          if (ar_hs_i) r_proto_err <= 1'b1;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign gnt_valid_o  = (r_state == StAddr);
  assign gnt_onehot_o = r_gnt_onehot;
  assign gnt_id_o     = r_gnt_id;
  assign busy_o       = (r_state != StIdle);
  assign ar_done_o    = (r_state == StResp);
  assign proto_err_o  = r_proto_err;

endmodule

// File: tb/tb_liteic_slave_rd_arbiter.sv
// Scoreboard bench for liteic_slave_rd_arbiter (NUM_REQ = 4): the driver pushes the
// expected grant id of each transaction; a monitor pops on every new grant and also
// checks that the grant is held and one-hot for as long as the node is busy.
module tb_liteic_slave_rd_arbiter;

  logic       clk;
  logic       rstn;
  logic [3:0] req;
  logic       ar_hs;
  logic       r_hs;
  logic       gnt_valid;
  logic [3:0] gnt_onehot;
  logic [1:0] gnt_id;
  logic       busy;
  logic       ar_done;
  logic       proto_err;

  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] exp_q[$];

  liteic_slave_rd_arbiter #(.NUM_REQ(4)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .req_i        (req),
    .ar_hs_i      (ar_hs),
    .r_hs_i       (r_hs),
    .gnt_valid_o  (gnt_valid),
    .gnt_onehot_o (gnt_onehot),
    .gnt_id_o     (gnt_id),
    .busy_o       (busy),
    .ar_done_o    (ar_done),
    .proto_err_o  (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_gnt_valid"}, 32'(gnt_valid), 0);
    chk({tag, "_onehot"}, 32'(gnt_onehot), 0);
    chk({tag, "_gnt_id"}, 32'(gnt_id), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ar_done"}, 32'(ar_done), 0);
    chk({tag, "_proto_err"}, 32'(proto_err), 0);
  endtask

  // Bounded wait for gnt_valid; a timeout counts as a failure.
  task automatic wait_valid();
    int n;
    n = 0;
    while (!gnt_valid && n < 8) begin
      step();
      n++;
    end
    if (!gnt_valid) chk("grant_timeout", 32'(gnt_valid), 1);
  endtask

  // Complete the current grant: AR handshake, then R handshake with req set to nxt.
  task automatic do_txn(input logic [3:0] nxt);
    wait_valid();
    ar_hs = 1'b1;
    step();
    ar_hs = 1'b0;
    chk("ar_done", 32'(ar_done), 1);
    chk("resp_gnt_valid", 32'(gnt_valid), 0);
    r_hs = 1'b1;
    req  = nxt;
    step();
    r_hs = 1'b0;
    if (nxt != 4'b0) chk("b2b_no_bubble", 32'(gnt_valid), 1);
    else             chk("back_to_idle", 32'(busy), 0);
  endtask

  // Monitor: new grant -> pop expected id; while busy -> grant held and one-hot.
  logic       prev_valid = 1'b0;
  logic [1:0] held_id    = 2'd0;
  initial begin
    forever begin
      @(negedge clk);
      if (gnt_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", 32'(gnt_id), 32'hffff_ffff);
        end else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          chk("grant_id", 32'(gnt_id), 32'(e));
          held_id = e;
        end
      end else if (busy) begin
        chk("grant_held", 32'(gnt_id), 32'(held_id));
      end
      if (busy) chk("onehot_inv", 32'(gnt_onehot), 32'(4'b0001 << gnt_id));
      prev_valid = gnt_valid;
    end
  end

  initial begin
    rstn  = 1'b0;
    req   = 4'b0;
    ar_hs = 1'b0;
    r_hs  = 1'b0;
    step();
    step();
    chk_idle_outputs("reset");
    rstn = 1'b1;

    // Single request with exact cycle timing.
    step();
    req = 4'b0100;
    exp_q.push_back(2'd2);
    step();
    chk("single_valid", 32'(gnt_valid), 1);
    chk("single_id", 32'(gnt_id), 2);
    chk("single_onehot", 32'(gnt_onehot), 32'h4);
    step();
    req = 4'b0;
    step();
    ar_hs = 1'b1;
    step();
    ar_hs = 1'b0;
    chk("single_ar_done", 32'(ar_done), 1);
    step();
    step();
    r_hs = 1'b1;
    step();
    r_hs = 1'b0;
    chk("single_idle_busy", 32'(busy), 0);
    chk("single_idle_onehot", 32'(gnt_onehot), 0);
    chk("single_id_kept", 32'(gnt_id), 2);
    chk("single_no_err", 32'(proto_err), 0);

    // Rotation from a fresh pointer: 0,1,2,3,0 back-to-back.
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    req = 4'b1111;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    step();
    do_txn(4'b1111);
    do_txn(4'b1111);
    do_txn(4'b1111);
    do_txn(4'b1111);
    do_txn(4'b0000);

    // Wrap-around: pointer is 1; grant 3 moves it to 0, so 1001 picks 0.
    req = 4'b1000;
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    do_txn(4'b1001);
    do_txn(4'b0000);

    // Grant stability: pointer is 1; request changes while in ADDR.
    req = 4'b0010;
    exp_q.push_back(2'd1);
    wait_valid();
    req = 4'b0100;
    step();
    chk("stable_id_a", 32'(gnt_id), 1);
    step();
    chk("stable_id_b", 32'(gnt_id), 1);
    exp_q.push_back(2'd2);
    do_txn(4'b0100);
    do_txn(4'b0000);

    // Protocol error: r_hs in IDLE, sticky across a transaction, cleared by reset.
    step();
    r_hs = 1'b1;
    step();
    r_hs = 1'b0;
    chk("perr_set", 32'(proto_err), 1);
    chk("perr_state_idle", 32'(busy), 0);
    req = 4'b0001;
    exp_q.push_back(2'd0);
    do_txn(4'b0000);
    chk("perr_sticky", 32'(proto_err), 1);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk("perr_cleared", 32'(proto_err), 0);

    // Reset in RESP: everything drops, pointer returns to 0.
    req = 4'b0100;
    exp_q.push_back(2'd2);
    wait_valid();
    ar_hs = 1'b1;
    step();
    ar_hs = 1'b0;
    chk("midresp_ar_done", 32'(ar_done), 1);
    req  = 4'b0;
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk_idle_outputs("midresp_reset");
    req = 4'b1010;
    exp_q.push_back(2'd1);
    do_txn(4'b0000);

    step();
    step();
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
